// File: rtl/switch_event_decoder_pkg.sv
// Shared switch timing constants and decoder state encodings.
// Debouncer and decoder timings live here so board-level retiming is one edit.
package switch_event_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } state_t;

  localparam int unsigned LONG_PRESS_25MHZ    = 12500000;  // 0.5 s
  localparam int unsigned DOUBLE_WINDOW_25MHZ = 6250000;   // 250 ms
  localparam int unsigned CNT_WIDTH_25MHZ     = 24;

  // True when val is representable in an unsigned counter of the given width.
  function automatic bit fits_width(input int unsigned val, input int unsigned width);
    if (width >= 32) return 1'b1;
    return (val >> width) == 0;
  endfunction

endpackage

// File: rtl/switch_edge_detect.sv
// Two-stage register on a debounced switch level, producing the registered
// level and single-cycle rise/fall strobes.
module switch_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sw_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      sw_d  <= 1'b0;
    end else begin
      level <= sw;
      sw_d  <= level;
    end
  end

  assign rise = level & ~sw_d;
  assign fall = ~level & sw_d;

endmodule

// File: rtl/switch_event_decoder.sv
// Classifies one debounced switch into registered one-cycle event pulses:
// press, release, single click, double click and long press.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// IDLE           | switch released, no gesture in progress
// PRESSED        | first press held, counting toward long press
// LONG_HELD      | long press already reported, waiting for release
// WAIT_SECOND    | short press released, counting the double-click window
// SECOND_PRESSED | second press of a double click held
module switch_event_decoder
  import switch_event_decoder_pkg::*;
#(
  parameter int unsigned c_LONG_PRESS_LIMIT = LONG_PRESS_25MHZ,
  parameter int unsigned c_DOUBLE_WINDOW    = DOUBLE_WINDOW_25MHZ,
  parameter int unsigned c_CNT_WIDTH        = CNT_WIDTH_25MHZ
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Click,
  output logic o_Double_Click,
  output logic o_Long_Press
);

  if (c_LONG_PRESS_LIMIT < 2 || c_DOUBLE_WINDOW < 2 ||
      !fits_width(c_LONG_PRESS_LIMIT, c_CNT_WIDTH) ||
      !fits_width(c_DOUBLE_WINDOW, c_CNT_WIDTH)) begin : g_bad_params
    $error("switch_event_decoder: timing limits must be >= 2 and fit in c_CNT_WIDTH");
  end

  localparam logic [c_CNT_WIDTH-1:0] LONG_LIM = c_CNT_WIDTH'(c_LONG_PRESS_LIMIT);
  localparam logic [c_CNT_WIDTH-1:0] WIN_LIM  = c_CNT_WIDTH'(c_DOUBLE_WINDOW);
  localparam logic [c_CNT_WIDTH-1:0] CNT_ONE  = c_CNT_WIDTH'(1);

  logic sw_level, sw_rise, sw_fall;

  switch_edge_detect u_edge (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .sw    (i_Switch),
    .level (sw_level),
    .rise  (sw_rise),
    .fall  (sw_fall)
  );

  state_t                 state_q, state_d;
  logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic press_d, rel_d, click_d, dbl_d, long_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      o_Press        <= 1'b0;
      o_Release      <= 1'b0;
      o_Click        <= 1'b0;
      o_Double_Click <= 1'b0;
      o_Long_Press   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      o_Press        <= press_d;
      o_Release      <= rel_d;
      o_Click        <= click_d;
      o_Double_Click <= dbl_d;
      o_Long_Press   <= long_d;
    end
  end

  // In the held states the level can only drop through a fall strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (sw_rise) state_d = ST_PRESSED;
      ST_PRESSED:
        if (sw_fall)                state_d = ST_WAIT_SECOND;
        else if (cnt_q == LONG_LIM) state_d = ST_LONG_HELD;
      ST_LONG_HELD:
        if (!sw_level) state_d = ST_IDLE;
      ST_WAIT_SECOND:
        if (sw_rise)               state_d = ST_SECOND_PRESSED;
        else if (cnt_q == WIN_LIM) state_d = ST_IDLE;
      ST_SECOND_PRESSED:
        if (!sw_level) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    click_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      ST_IDLE:
        if (sw_rise) begin
          cnt_d   = CNT_ONE;
          press_d = 1'b1;
        end
      ST_PRESSED:
        if (sw_fall) begin
          cnt_d = CNT_ONE;
          rel_d = 1'b1;
        end else if (cnt_q == LONG_LIM) begin
          long_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      ST_LONG_HELD:
        rel_d = ~sw_level;
      ST_WAIT_SECOND:
        if (sw_rise) begin
          press_d = 1'b1;
          dbl_d   = 1'b1;
        end else if (cnt_q == WIN_LIM) begin
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      ST_SECOND_PRESSED:
        rel_d = ~sw_level;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_switch_event_decoder.sv
// Randomized and directed bench for switch_event_decoder, checked against a
// gesture-level timing model built from the sampled switch history.
module tb_switch_event_decoder;

  localparam int L    = 10;
  localparam int W    = 6;
  localparam int MAXC = 8192;

  logic i_Clk, i_Rst_L, i_Switch;
  logic o_Press, o_Release, o_Click, o_Double_Click, o_Long_Press;

  switch_event_decoder #(
    .c_LONG_PRESS_LIMIT (L),
    .c_DOUBLE_WINDOW    (W),
    .c_CNT_WIDTH        (4)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Switch       (i_Switch),
    .o_Press        (o_Press),
    .o_Release      (o_Release),
    .o_Click        (o_Click),
    .o_Double_Click (o_Double_Click),
    .o_Long_Press   (o_Long_Press)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Event vectors are {press, release, click, double, long}.
  logic       lvl  [MAXC];
  logic [4:0] obs  [MAXC];
  logic [4:0] expv [MAXC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [4:0] outs();
    return {o_Press, o_Release, o_Click, o_Double_Click, o_Long_Press};
  endfunction

  // Drive one sample at the falling edge, observe outputs after the next rising edge.
  task automatic step(input logic v);
    i_Switch = v;
    if (cyc + 1 < MAXC) lvl[cyc+1] = v;
    @(posedge i_Clk);
    cyc++;
    @(negedge i_Clk);
    if (cyc < MAXC) obs[cyc] = outs();
  endtask

  task automatic seg(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic mark(input int t, input int b);
    if (t >= 0 && t < MAXC) expv[t][b] = 1'b1;
  endtask

  // Gesture model: a level change sampled at k is reported at k+1. A press
  // held past L cycles is a long press; a short press followed by another
  // press within W cycles of its release is a double click, else a click.
  task automatic model_and_compare(input int last);
    int pt[$];
    int rt[$];
    int i, p, r;
    for (int c = 0; c < MAXC; c++) expv[c] = '0;
    for (int k = 1; k <= last; k++) begin
      if (lvl[k] && !lvl[k-1]) pt.push_back(k + 1);
      if (!lvl[k] && lvl[k-1]) rt.push_back(k + 1);
    end
    i = 0;
    while (i < pt.size()) begin
      p = pt[i];
      r = (i < rt.size()) ? rt[i] : 32'h3fff_ffff;
      mark(p, 4);
      mark(r, 3);
      if (r > p + L) begin
        mark(p + L, 0);
        i++;
      end else if (i + 1 < pt.size() && pt[i+1] <= r + W) begin
        mark(pt[i+1], 4);
        mark(pt[i+1], 1);
        if (i + 1 < rt.size()) mark(rt[i+1], 3);
        i += 2;
      end else begin
        mark(r + W, 2);
        i++;
      end
    end
    for (int c = 1; c <= last; c++)
      check($sformatf("ev_c%0d", c), obs[c], expv[c]);
  endtask

  int s, hi, lo, main_end, npulse;

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      lvl[c] = 1'b0;
      obs[c] = '0;
    end
    i_Switch = 1'b0;
    i_Rst_L  = 1'b0;
    repeat (3) @(negedge i_Clk);
    check("reset_outs", outs(), 5'b00000);
    i_Rst_L = 1'b1;

    seg(0, 4);

    // single click
    s = cyc;
    seg(1, 3); seg(0, 20);
    check("click_press",   obs[s+2],  5'b10000);
    check("click_release", obs[s+5],  5'b01000);
    check("click_early",   obs[s+10], 5'b00000);
    check("click_fire",    obs[s+11], 5'b00100);

    // double click
    s = cyc;
    seg(1, 3); seg(0, 3); seg(1, 3); seg(0, 20);
    check("dbl_second", obs[s+8],  5'b10010);
    check("dbl_release", obs[s+11], 5'b01000);
    npulse = 0;
    for (int c = s; c < cyc; c++) npulse += int'(obs[c][2]);
    check("dbl_no_click", npulse, 0);

    // long press
    s = cyc;
    seg(1, 25); seg(0, 20);
    check("long_fire",    obs[s+12], 5'b00001);
    check("long_release", obs[s+27], 5'b01000);

    // fall coincides with counter == L
    s = cyc;
    seg(1, L); seg(0, 20);
    check("bnd_long_rel", obs[s+12], 5'b01000);
    npulse = 0;
    for (int c = s; c < cyc; c++) npulse += int'(obs[c][0]) + int'(obs[c][2]);
    check("bnd_long_none", npulse, 1);

    // rise coincides with counter == W
    s = cyc;
    seg(1, 3); seg(0, W); seg(1, 3); seg(0, 20);
    check("bnd_win_dbl", obs[s+11], 5'b10010);
    npulse = 0;
    for (int c = s; c < cyc; c++) npulse += int'(obs[c][2]);
    check("bnd_win_noclick", npulse, 0);

    // randomized gestures biased toward the timing boundaries
    for (int n = 0; n < 90; n++) begin
      case ($urandom_range(0, 3))
        0:       hi = $urandom_range(1, 3);
        1:       hi = $urandom_range(L - 1, L + 1);
        2:       hi = $urandom_range(1, L + 4);
        default: hi = $urandom_range(L + 2, L + 8);
      endcase
      case ($urandom_range(0, 3))
        0:       lo = $urandom_range(1, 3);
        1:       lo = $urandom_range(W - 1, W + 1);
        2:       lo = $urandom_range(1, W + 4);
        default: lo = $urandom_range(W + 2, W + 12);
      endcase
      seg(1, hi);
      seg(0, lo);
    end
    seg(0, L + W + 10);
    main_end = cyc;
    model_and_compare(main_end);

    // async reset while in WAIT_SECOND, with o_Release still high
    s = cyc;
    seg(1, 3); seg(0, 2);
    check("rst_rel_before", o_Release, 1);
    #1 i_Rst_L = 1'b0;
    #1 check("rst_async_outs", outs(), 5'b00000);
    seg(0, 3);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    s = cyc;
    seg(0, 20);
    npulse = 0;
    for (int c = s + 1; c <= cyc; c++) npulse += int'(obs[c] != 5'b00000);
    check("rst_no_click", npulse, 0);

    // switch held high through reset release
    i_Rst_L = 1'b0;
    seg(1, 3);
    i_Rst_L = 1'b1;
    step(1);
    check("rst_hold_first",  o_Press, 0);
    step(1);
    check("rst_hold_press",  o_Press, 1);
    step(1);
    check("rst_hold_pulse1", o_Press, 0);
    seg(0, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
